// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared PAM4 levels, widths, PRBS taps, FSM states and FFE helpers
package serdes_pkg;

  localparam int SAMPLE_W = 8;
  localparam int TAP_W    = 6;
  localparam int SYM_W    = 3;
  localparam int ACC_W    = 10;

  localparam logic signed [SYM_W-1:0] PAM4_M3 = 3'b101;
  localparam logic signed [SYM_W-1:0] PAM4_M1 = 3'b111;
  localparam logic signed [SYM_W-1:0] PAM4_P1 = 3'b001;
  localparam logic signed [SYM_W-1:0] PAM4_P3 = 3'b011;

  // Fibonacci LFSR: feedback is state[W-1] ^ state[TAP-1]
  localparam int PRBS7_W   = 7;
  localparam int PRBS7_TAP = 6;
  localparam int PRBS15_W   = 15;
  localparam int PRBS15_TAP = 14;

  localparam logic signed [ACC_W-1:0] ACC_HI = 10'sd127;
  localparam logic signed [ACC_W-1:0] ACC_LO = -10'sd128;

  typedef enum logic [1:0] {IDLE, FILL, RUN} tx_state_t;

  function automatic logic signed [SYM_W-1:0] gray_map(input logic [1:0] bits);
    logic signed [SYM_W-1:0] lvl;
    case (bits)
      2'b00:   lvl = PAM4_M3;
      2'b01:   lvl = PAM4_M1;
      2'b11:   lvl = PAM4_P1;
      default: lvl = PAM4_P3;
    endcase
    return lvl;
  endfunction

  function automatic logic signed [ACC_W-1:0] tap_mul(input logic [TAP_W-1:0] tap,
                                                       input logic signed [SYM_W-1:0] x);
    logic signed [ACC_W-1:0] t;
    logic signed [ACC_W-1:0] s;
    t = {{(ACC_W-TAP_W){tap[TAP_W-1]}}, tap};
    s = {{(ACC_W-SYM_W){x[SYM_W-1]}}, x};
    return t * s;
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [ACC_W-1:0] acc);
    logic signed [SAMPLE_W-1:0] r;
    if (acc > ACC_HI)      r = 8'h7F;
    else if (acc < ACC_LO) r = 8'h80;
    else                   r = acc[SAMPLE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// rtl/prbs_lfsr.sv - parameterised Fibonacci LFSR advancing two bits per step
// An all-zero seed would lock the register, so it is replaced by 1.
module prbs_lfsr #(
  parameter int          WIDTH = 7,
  parameter int          TAP   = 6,
  parameter logic [15:0] SEED  = 16'h1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_advance,
  output logic [1:0] o_bits
);

  localparam logic [WIDTH-1:0] SEED_V =
    (SEED[WIDTH-1:0] == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED[WIDTH-1:0];

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_step1;
  logic [WIDTH-1:0] w_step2;
  logic             w_b0;
  logic             w_b1;

  always_comb begin
    w_b0    = r_state[WIDTH-1] ^ r_state[TAP-1];
    w_step1 = {r_state[WIDTH-2:0], w_b0};
    w_b1    = w_step1[WIDTH-1] ^ w_step1[TAP-1];
    w_step2 = {w_step1[WIDTH-2:0], w_b1};
  end

  // first generated bit lands in the MSB
  assign o_bits = {w_b0, w_b1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_state <= SEED_V;
    else if (i_load)    r_state <= SEED_V;
    else if (i_advance) r_state <= w_step2;
  end

endmodule

// File: rtl/tx_prbs_pam4_ffe.sv
// rtl/tx_prbs_pam4_ffe.sv - PRBS to Gray PAM4 symbols, 3-tap FFE, saturated 8-bit samples
// TX_ERR_INJECT_EN adds err_inject, which flips the MSB bit of the next generated symbol.
module tx_prbs_pam4_ffe
  import serdes_pkg::*;
#(
  parameter int          SYM_DIV  = 4,
  parameter int          PRBS_SEL = 0,
  parameter logic [15:0] SEED     = 16'h1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                prbs_reseed,
  input  logic [TAP_W-1:0]    tap_pre,
  input  logic [TAP_W-1:0]    tap_main,
  input  logic [TAP_W-1:0]    tap_post,
`ifdef TX_ERR_INJECT_EN
  input  logic                err_inject,
`endif
  output logic [SAMPLE_W-1:0] signal_out,
  output logic                signal_out_valid
);

  localparam int LFSR_W   = (PRBS_SEL == 0) ? PRBS7_W : PRBS15_W;
  localparam int LFSR_TAP = (PRBS_SEL == 0) ? PRBS7_TAP : PRBS15_TAP;
  localparam int DIV_W    = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);

  tx_state_t                r_state;
  logic [DIV_W-1:0]         r_div_cnt;
  logic [1:0]               r_fill_cnt;
  logic signed [SYM_W-1:0]  r_x_pre;
  logic signed [SYM_W-1:0]  r_x_main;
  logic signed [SYM_W-1:0]  r_x_post;

  logic                     w_tick;
  logic [1:0]               w_bits;
  logic [1:0]               w_sym_bits;
  logic signed [SYM_W-1:0]  w_sym;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [SAMPLE_W-1:0] w_sat;

  // reseed wins over a coincident tick, so it also blocks the LFSR advance
  assign w_tick = enable && !prbs_reseed && (r_div_cnt == DIV_LAST);

  prbs_lfsr #(
    .WIDTH (LFSR_W),
    .TAP   (LFSR_TAP),
    .SEED  (SEED)
  ) u_lfsr (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_load    (prbs_reseed),
    .i_advance (w_tick),
    .o_bits    (w_bits)
  );

`ifdef TX_ERR_INJECT_EN
  logic r_err_flag;
  logic w_err_apply;

  // a pulse landing on a tick corrupts that tick's symbol directly
  assign w_err_apply = r_err_flag | err_inject;
  assign w_sym_bits  = {w_bits[1] ^ w_err_apply, w_bits[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_err_flag <= 1'b0;
    else if (w_tick)     r_err_flag <= 1'b0;
    else if (err_inject) r_err_flag <= 1'b1;
  end
`else
  assign w_sym_bits = w_bits;
`endif

  assign w_sym = gray_map(w_sym_bits);

  // evaluated on the post-shift delay line so the new symbol is included
  assign w_acc = tap_mul(tap_pre, w_sym) + tap_mul(tap_main, r_x_pre) + tap_mul(tap_post, r_x_main);
  assign w_sat = sat_sample(w_acc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_div_cnt        <= '0;
      r_fill_cnt       <= '0;
      r_x_pre          <= '0;
      r_x_main         <= '0;
      r_x_post         <= '0;
      signal_out       <= '0;
      signal_out_valid <= 1'b0;
    end else if (prbs_reseed) begin
      r_state          <= enable ? FILL : IDLE;
      r_div_cnt        <= '0;
      r_fill_cnt       <= '0;
      r_x_pre          <= '0;
      r_x_main         <= '0;
      r_x_post         <= '0;
      signal_out_valid <= 1'b0;
    end else if (!enable) begin
      r_state          <= IDLE;
      r_div_cnt        <= '0;
      r_fill_cnt       <= '0;
      r_x_pre          <= '0;
      r_x_main         <= '0;
      r_x_post         <= '0;
      signal_out_valid <= 1'b0;
    end else begin
      r_div_cnt        <= w_tick ? '0 : r_div_cnt + 1'b1;
      signal_out_valid <= 1'b0;
      if (r_state == IDLE) r_state <= FILL;
      if (w_tick) begin
        r_x_post <= r_x_main;
        r_x_main <= r_x_pre;
        r_x_pre  <= w_sym;
        // the third fill tick already carries a full delay line
        if (r_state == RUN || r_fill_cnt == 2'd2) begin
          r_state          <= RUN;
          signal_out       <= w_sat;
          signal_out_valid <= 1'b1;
        end else begin
          r_fill_cnt <= r_fill_cnt + 1'b1;
        end
      end
    end
  end

endmodule
